// File: rtl/mil_transmitter.sv
// MIL-STD-1553 Manchester-II word transmitter: sync, 16 data bits MSB first, odd parity, then an idle gap.
// Optional build macro MIL_TX_PARITY_INJECT_EN: *ERR word types are sent with inverted parity.
module mil_transmitter #(
  parameter int HALF_PERIOD  = 50,
  parameter int GAP_HALFBITS = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [1:0]  in_type,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        TXout,
  output logic        nTXout,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a word transfers on the clk edge where in_valid & in_ready are both high;
  // in_ready never depends on in_valid, and in_valid may drop while in_ready is low.

  localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(HALF_PERIOD - 1);
  localparam logic [5:0]    GAP_LAST = 6'(GAP_HALFBITS - 1);

`ifdef MIL_TX_PARITY_INJECT_EN
  localparam logic INJECT = 1'b1;
`else
  localparam logic INJECT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    hb_q, hb_d;
  logic          is_data_q, is_data_d;
  logic [15:0]   data_q, data_d;
  logic          par_q, par_d;
  logic          tx_q, ntx_q;

  logic          hb_end;
  logic          accept;
  logic          line_bit;
  logic          line_active;
  logic [5:0]    data_idx;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    hb_d      = hb_q;
    is_data_d = is_data_q;
    data_d    = data_q;
    par_d     = par_q;
    in_ready  = 1'b0;
    hb_end    = (timer_q == TMAX);

    if (state_q != S_IDLE) begin
      timer_d = hb_end ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        timer_d  = '0;
        hb_d     = 6'd0;
        in_ready = enable;
      end
      S_SYNC: begin
        if (hb_end) begin
          hb_d = hb_q + 6'd1;
          if (hb_q == 6'd5) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hb_end) begin
          hb_d = hb_q + 6'd1;
          if (hb_q == 6'd37) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (hb_end) begin
          if (hb_q == 6'd39) begin
            // Last clk of the frame: a chained word starts with no idle half-bits.
            in_ready = enable;
            hb_d     = 6'd0;
            state_d  = S_GAP;
          end else begin
            hb_d = hb_q + 6'd1;
          end
        end
      end
      S_GAP: begin
        if (hb_end) begin
          if (hb_q == GAP_LAST) begin
            hb_d    = 6'd0;
            state_d = S_IDLE;
          end else begin
            hb_d = hb_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    accept = in_ready & in_valid;
    if (accept) begin
      state_d   = S_SYNC;
      timer_d   = '0;
      hb_d      = 6'd0;
      is_data_d = in_type[1];
      data_d    = in_data;
      par_d     = ~(^in_data) ^ (INJECT & in_type[0]);
    end
  end

  always_comb begin
    line_bit    = 1'b0;
    line_active = 1'b0;
    data_idx    = hb_q - 6'd6;
    case (state_q)
      S_SYNC: begin
        line_active = 1'b1;
        line_bit    = is_data_q ? (hb_q >= 6'd3) : (hb_q < 6'd3);
      end
      S_DATA: begin
        line_active = 1'b1;
        line_bit    = data_q[4'd15 - data_idx[4:1]] ^ data_idx[0];
      end
      S_PARITY: begin
        line_active = 1'b1;
        line_bit    = par_q ^ hb_q[0];
      end
      default: begin
        line_active = 1'b0;
        line_bit    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      hb_q      <= 6'd0;
      is_data_q <= 1'b0;
      data_q    <= 16'd0;
      par_q     <= 1'b0;
      tx_q      <= 1'b0;
      ntx_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hb_q      <= hb_d;
      is_data_q <= is_data_d;
      data_q    <= data_d;
      par_q     <= par_d;
      // Line follows the state by one clk, so each half-bit still spans HALF_PERIOD clks.
      tx_q      <= line_active & line_bit;
      ntx_q     <= line_active & ~line_bit;
    end
  end

  assign TXout       = tx_q;
  assign nTXout      = ntx_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mil_transmitter.sv
// Directed bench for mil_transmitter: checks line pattern per half-bit, chaining, gap, reset and enable.
module tb_mil_transmitter;

  localparam int HP  = 50;
  localparam int GAP = 8;

  localparam logic [1:0] WSERV    = 2'd0;
  localparam logic [1:0] WSERVERR = 2'd1;
  localparam logic [1:0] WDATA    = 2'd2;
  localparam logic [1:0] WDATAERR = 2'd3;

  logic        clk;
  logic        nRst;
  logic        enable;
  logic        in_valid;
  logic [1:0]  in_type;
  logic [15:0] in_data;
  logic        in_ready;
  logic        TXout;
  logic        nTXout;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks;
  int failures;

  mil_transmitter #(.HALF_PERIOD(HP), .GAP_HALFBITS(GAP)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_type     (in_type),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .TXout       (TXout),
    .nTXout      (nTXout),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word and return #1 after the edge that accepts it.
  task automatic send(input logic [1:0] t, input logic [15:0] d);
    int n;
    in_valid = 1'b1;
    in_type  = t;
    in_data  = d;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 200), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_type  = 2'd0;
    in_data  = 16'hDEAD;
  endtask

  // Called #1 after the accept edge; returns #1 after the edge ending hb39.
  task automatic check_frame(input logic [39:0] bits, input logic from_idle,
                             input int drop_en_hb, input logic exp_end_ready);
    logic b;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    if (from_idle) chk("latency_idle_line", {TXout, nTXout}, 0);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        repeat (HP) @(posedge clk);
        @(negedge clk);
      end
      b = bits[39-k];
      chk($sformatf("hb%0d_line", k), {TXout, nTXout}, {b, ~b});
      chk($sformatf("hb%0d_ready", k), in_ready, 0);
      if (k == drop_en_hb) enable = 1'b0;
    end
    repeat (HP - 2) @(posedge clk);
    @(negedge clk);
    chk("end_of_frame_ready", in_ready, exp_end_ready);
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge ending hb39 of a frame that was not chained.
  task automatic check_gap(input logic exp_ready);
    @(posedge clk);
    @(negedge clk);
    chk("gap_start_line", {TXout, nTXout}, 0);
    chk("gap_start_busy", busy, 1);
    repeat (GAP * HP - 2) @(posedge clk);
    @(negedge clk);
    chk("gap_last_busy", busy, 1);
    chk("gap_last_line", {TXout, nTXout}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("gap_end_busy", busy, 0);
    chk("gap_end_ready", in_ready, exp_ready);
  endtask

  logic [39:0] f_serv_0000, f_data_ffff, f_serv_a5a5, f_data_1234, f_derr_0001;

  initial begin
    checks   = 0;
    failures = 0;
    f_serv_0000 = {6'b111000, 32'h55555555, 2'b10};
    f_data_ffff = {6'b000111, 32'hAAAAAAAA, 2'b10};
    f_serv_a5a5 = {6'b111000, 32'h99669966, 2'b10};
    f_data_1234 = {6'b000111, 32'h56595A65, 2'b01};
`ifdef MIL_TX_PARITY_INJECT_EN
    f_derr_0001 = {6'b000111, 32'h55555556, 2'b10};
`else
    f_derr_0001 = {6'b000111, 32'h55555556, 2'b01};
`endif

    nRst     = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_type  = 2'd0;
    in_data  = 16'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", {TXout, nTXout}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_state", dbg_state, 0);
    nRst = 1'b1;
    @(negedge clk);
    chk("idle_ready_disabled", in_ready, 0);
    enable = 1'b1;
    #1;
    chk("idle_ready_enabled", in_ready, 1);

    // WSERV 0x0000 from idle
    send(WSERV, 16'h0000);
    check_frame(f_serv_0000, 1'b1, -1, 1'b1);
    check_gap(1'b1);

    // Back-to-back: WSERV 0xA5A5 then WDATA 0x1234 with no idle
    send(WSERV, 16'hA5A5);
    in_valid = 1'b1;
    in_type  = WDATA;
    in_data  = 16'h1234;
    check_frame(f_serv_a5a5, 1'b1, -1, 1'b1);
    in_valid = 1'b0;
    in_data  = 16'hBEEF;
    check_frame(f_data_1234, 1'b0, -1, 1'b1);
    check_gap(1'b1);

    // Lone WDATA 0xFFFF from idle
    send(WDATA, 16'hFFFF);
    check_frame(f_data_ffff, 1'b1, -1, 1'b1);
    check_gap(1'b1);

    // Reset mid-frame at hb20
    send(WSERV, 16'hA5A5);
    repeat (1 + 20 * HP + 10) @(posedge clk);
    @(negedge clk);
    chk("hb20_before_reset", {TXout, nTXout}, 2'b10);
    #1;
    nRst = 1'b0;
    #1;
    chk("async_rst_line", {TXout, nTXout}, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_state", dbg_state, 0);
    @(negedge clk);
    nRst = 1'b1;
    send(WSERV, 16'h0000);
    check_frame(f_serv_0000, 1'b1, -1, 1'b1);
    check_gap(1'b1);

    // Enable dropped at hb10 with the next word held valid
    send(WSERV, 16'hA5A5);
    in_valid = 1'b1;
    in_type  = WDATA;
    in_data  = 16'h1234;
    check_frame(f_serv_a5a5, 1'b1, 10, 1'b0);
    check_gap(1'b0);
    repeat (5) @(negedge clk);
    chk("disabled_idle_ready", in_ready, 0);
    chk("disabled_idle_busy", busy, 0);
    chk("disabled_idle_state", dbg_state, 0);
    in_valid = 1'b0;
    enable   = 1'b1;

    // WDATAERR 0x0001: parity depends on the injection build option
    @(negedge clk);
    send(WDATAERR, 16'h0001);
    check_frame(f_derr_0001, 1'b1, -1, 1'b1);
    check_gap(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
